led_pattern_ctrl: RTL and testbench
===================================

# led_pattern_ctrl

Sequencer for the 8-LED display bank. Generates the step rate from `clk` with a programmable divider, holds the current pattern mode and direction, and advances the LED pattern once per step. Accepts mode changes through a valid/ready handshake and applies them only at step boundaries. Sits between the board switch/key decode logic and the `LED[7:0]` pins.

## Interface

- `DIV_W`, 26: divider width in bits.
- `DEFAULT_DIV`, 25_000_000: divider value loaded at reset (0.5 s step at 50 MHz).

- `clk` input 1: system clock, all logic on rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `run` input 1: 1 = divider counts and pattern steps; 0 = pause, all state held.
- `div_load` input 1: single-cycle strobe that loads `div_value`.
- `div_value` input DIV_W: new step period in clk cycles; 0 is treated as 1.
- `mode_req_valid` input 1: mode change request.
- `mode_req` input 2: requested mode; 0 BOUNCE, 1 ROT_L, 2 ROT_R, 3 FILL.
- `mode_req_ready` output 1: controller can accept a request.
- `LED` output 8: display pattern.
- `dir` output 1: 0 = moving left (toward bit 7), 1 = moving right.
- `step_pulse` output 1: high for one cycle, in the first cycle a new `LED` value is visible.
- `mode` output 2: mode currently applied.

## Operation

- Reset values: LED=8'h01, dir=0, mode=BOUNCE, div=DEFAULT_DIV, cnt=0, step_pulse=0, pending=0, mode_req_ready=1.
- Divider: while run=1, cnt counts 0..div-1. At the edge where cnt==div-1, cnt becomes 0, LED and dir are updated, and step_pulse is registered to 1. When run=0, cnt, LED, dir and pending are held and step_pulse=0.
- div_load: at that edge, div becomes max(div_value,1) and cnt becomes 0. div_load takes priority over a step in the same cycle, so no step occurs in that cycle.
- BOUNCE (one-hot): for dir=0, shift left while LED<8'h80. At 8'h80, LED becomes 8'h40 and dir becomes 1. For dir=1, shift right while LED>8'h01. At 8'h01, LED becomes 8'h02 and dir becomes 0. The period is 14 steps.
- ROT_L: rotate left, so 8'h80 becomes 8'h01. dir=0.
- ROT_R: rotate right, so 8'h01 becomes 8'h80. dir=1.
- FILL (Johnson): LED becomes {LED[6:0], ~LED[7]}. The period is 16 steps (00, 01, 03, …, FF, FE, …, 80, 00). dir=0.
- Mode handshake:
  - A request is accepted when valid and ready are both 1. On acceptance, the requested mode is captured into pending_mode, pending becomes 1, and ready becomes 0 on the next cycle.
  - While pending=1, valid is ignored.
- Apply: at the next step edge with pending=1, mode becomes pending_mode and pending becomes 0. LED is loaded with the start pattern instead of the next pattern:
  - BOUNCE, ROT_L, FILL: LED=8'h01, dir=0.
  - ROT_R: LED=8'h80, dir=1.
  - step_pulse=1 on this step. ready returns to 1 in the following cycle.
  - Requesting the mode already in use still reloads the start pattern.
- Pending with run=0: the request stays pending indefinitely and ready stays 0.
- div_load and acceptance in the same cycle: both take effect. The apply happens at the first step under the new divider.
- Reset mid-operation: all state returns to reset values immediately. Any pending request is lost.

## Timing

- With run=1 from reset release and no loads, step_pulse first asserts at cycle div after release (cycle 1 is the first edge after release), then every div cycles.
- LED, dir, mode and step_pulse are registered. There is no combinational path from any input to any output.
- Mode-change latency: from acceptance to the apply step is between 1 and div cycles while run=1.
- A div_load restarts the period: the next step occurs div_value cycles after the load edge.

## Structure

- Shared package `led_ctrl_pkg`:
  - `led_mode_e` enum (BOUNCE, ROT_L, ROT_R, FILL).
  - Constants `LED_START_L`=8'h01 and `LED_START_R`=8'h80.
  - Function `led_next(mode, led, dir)` returning the next {led, dir}.
- Sub-module `led_step_div`: holds cnt and div, implements div_load and the zero clamp, and outputs a `step` strobe gated by run.
- Top-level logic: pattern registers plus a 2-state handshake FSM.
  - IDLE (ready=1) moves to PENDING on acceptance.
  - PENDING (ready=0) returns to IDLE on the apply step.

## Test plan

- Reset release with DEFAULT_DIV overridden to 4 and run=1: step_pulse at cycles 4, 8, 12… LED follows 01, 02, 04, … 80, 40, … 01, 02. dir flips on the steps that load 40 and 02.
- div_load with div_value=0 at an arbitrary cycle: no step that cycle, then step_pulse every cycle and LED advances each cycle.
- Request ROT_R mid-period with div=4: ready drops next cycle. At the next step, LED=80, dir=1, mode=2, then 40, 20, …, 01, 80. ready returns 1 the cycle after the apply step.
- FILL from reset with div=1: LED sequence 01, 03, 07, 0F, 1F, 3F, 7F, FF, FE, FC, F8, F0, E0, C0, 80, 00, 01.
- Set run=0 with a request pending for 50 cycles: LED, cnt and pending are frozen, ready=0 and step_pulse=0. After run=1, the remaining count completes and then the apply occurs.
- Assert reset while PENDING in ROT_L mode: LED=01, mode=BOUNCE, ready=1 and step_pulse=0 without a clock edge. The request is discarded.

Source files
------------

// File: rtl/led_ctrl_pkg.sv
// Shared types, constants and pattern-step helpers for the LED sequencer.
package led_ctrl_pkg;

    // Pattern modes, encoded to match the mode_req/mode port values.
    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        ROT_L  = 2'd1,
        ROT_R  = 2'd2,
        FILL   = 2'd3
    } led_mode_e;

    // Mode-change handshake states.
    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_e;

    localparam logic [7:0] LED_START_L = 8'h01;
    localparam logic [7:0] LED_START_R = 8'h80;

    // Next {led, dir} for one step of the given mode.
    function automatic logic [8:0] led_next(input led_mode_e mode,
                                            input logic [7:0] led,
                                            input logic       dir);
        logic [7:0] nled;
        logic       ndir;
        nled = led;
        ndir = dir;
        case (mode)
            BOUNCE: begin
                if (!dir) begin
                    if (led == 8'h80) begin
                        nled = 8'h40;
                        ndir = 1'b1;
                    end else begin
                        nled = {led[6:0], 1'b0};
                        ndir = 1'b0;
                    end
                end else begin
                    if (led == 8'h01) begin
                        nled = 8'h02;
                        ndir = 1'b0;
                    end else begin
                        nled = {1'b0, led[7:1]};
                        ndir = 1'b1;
                    end
                end
            end
            ROT_L: begin
                nled = {led[6:0], led[7]};
                ndir = 1'b0;
            end
            ROT_R: begin
                nled = {led[0], led[7:1]};
                ndir = 1'b1;
            end
            FILL: begin
                nled = {led[6:0], ~led[7]};
                ndir = 1'b0;
            end
            default: begin
                nled = led;
                ndir = dir;
            end
        endcase
        return {nled, ndir};
    endfunction

    // Start {led, dir} loaded when a mode change is applied.
    function automatic logic [8:0] led_start(input led_mode_e mode);
        if (mode == ROT_R) begin
            return {LED_START_R, 1'b1};
        end
        return {LED_START_L, 1'b0};
    endfunction

endpackage

// File: rtl/led_step_div.sv
// Programmable step-rate divider: counts 0..div-1 while run is high.
module led_step_div #(
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             step
);

    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RESET =
        (DEFAULT_DIV == 0) ? DIV_ONE : DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             wrap;

    assign wrap = (cnt == (div - DIV_ONE));

    // A load outranks a step in the same cycle, so the strobe is masked by it.
    assign step = run && !div_load && wrap;

    // Divider value and period counter; a load restarts the period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div <= DIV_RESET;
            cnt <= '0;
        end else if (div_load) begin
            div <= (div_value == '0) ? DIV_ONE : div_value;
            cnt <= '0;
        end else if (run) begin
            if (wrap) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_ONE;
            end
        end
    end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED bank sequencer: step divider, pattern registers and mode handshake.
module led_pattern_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    input  logic             mode_req_valid,
    input  logic [1:0]       mode_req,
    output logic             mode_req_ready,
    output logic [7:0]       LED,
    output logic             dir,
    output logic             step_pulse,
    output logic [1:0]       mode
);

    logic       step;
    hs_state_e  state, state_n;
    led_mode_e  cur_mode, cur_mode_n;
    led_mode_e  pending_mode, pending_mode_n;
    logic [7:0] led_q, led_n;
    logic       dir_q, dir_n;
    logic       pulse_q, pulse_n;

    led_step_div #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_div (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .div_load  (div_load),
        .div_value (div_value),
        .step      (step)
    );

    // State, pattern and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= HS_IDLE;
            pending_mode <= BOUNCE;
            cur_mode     <= BOUNCE;
            led_q        <= LED_START_L;
            dir_q        <= 1'b0;
            pulse_q      <= 1'b0;
        end else begin
            state        <= state_n;
            pending_mode <= pending_mode_n;
            cur_mode     <= cur_mode_n;
            led_q        <= led_n;
            dir_q        <= dir_n;
            pulse_q      <= pulse_n;
        end
    end

    // Handshake next-state and next pattern; a step in PENDING applies the
    // queued mode and loads its start pattern instead of advancing.
    always_comb begin
        state_n        = state;
        pending_mode_n = pending_mode;
        cur_mode_n     = cur_mode;
        led_n          = led_q;
        dir_n          = dir_q;
        pulse_n        = 1'b0;

        case (state)
            HS_IDLE: begin
                if (mode_req_valid) begin
                    state_n        = HS_PENDING;
                    pending_mode_n = led_mode_e'(mode_req);
                end
            end
            HS_PENDING: begin
                if (step) begin
                    state_n = HS_IDLE;
                end
            end
            default: state_n = HS_IDLE;
        endcase

        if (step) begin
            pulse_n = 1'b1;
            if (state == HS_PENDING) begin
                cur_mode_n     = pending_mode;
                {led_n, dir_n} = led_start(pending_mode);
            end else begin
                {led_n, dir_n} = led_next(cur_mode, led_q, dir_q);
            end
        end
    end

    assign mode_req_ready = (state == HS_IDLE);
    assign LED            = led_q;
    assign dir            = dir_q;
    assign step_pulse     = pulse_q;
    assign mode           = cur_mode;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench for led_pattern_ctrl with hand-computed step vectors.
module tb_led_pattern_ctrl;

    localparam int unsigned DIV_W = 26;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  led;
        logic        dir;
        logic [1:0]  mode;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             run;
    logic             div_load;
    logic [DIV_W-1:0] div_value;
    logic             mode_req_valid;
    logic [1:0]       mode_req;
    logic             mode_req_ready;
    logic [7:0]       LED;
    logic             dir;
    logic             step_pulse;
    logic [1:0]       mode;

    logic [31:0] cyc;
    int          checks;
    int          errors;
    exp_t        q[$];

    led_pattern_ctrl #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .div_load       (div_load),
        .div_value      (div_value),
        .mode_req_valid (mode_req_valid),
        .mode_req       (mode_req),
        .mode_req_ready (mode_req_ready),
        .LED            (LED),
        .dir            (dir),
        .step_pulse     (step_pulse),
        .mode           (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: 1 is the first rising edge after reset release.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int c, input logic [7:0] l, input logic d, input logic [1:0] m);
        exp_t e;
        e.cyc  = 32'(c);
        e.led  = l;
        e.dir  = d;
        e.mode = m;
        q.push_back(e);
    endtask

    // Waits for the falling edge at which cyc == n, with a bounded budget.
    task automatic wait_cyc(input int n);
        int budget;
        budget = 400;
        do begin
            @(negedge clk);
            budget--;
        end while (cyc != 32'(n) && budget > 0);
        if (cyc != 32'(n)) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout actual=%0d required=%0d", cyc, n);
        end
    endtask

    // Pops and compares an expected step whenever the DUT presents step_pulse.
    task automatic monitor_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && step_pulse) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL step_unexpected actual_cycle=%0d led=%0h required=no_step", cyc, LED);
                end else begin
                    e = q.pop_front();
                    chk("step_cycle", cyc, e.cyc);
                    chk("step_led", 32'(LED), 32'(e.led));
                    chk("step_dir", 32'(dir), 32'(e.dir));
                    chk("step_mode", 32'(mode), 32'(e.mode));
                end
            end
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_led", 32'(LED), 32'h01);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_ready", 32'(mode_req_ready), 32'h1);
        chk("rst_pulse", 32'(step_pulse), 32'h0);
    endtask

    logic [7:0] bnc_led [15];
    logic       bnc_dir [15];
    logic [7:0] fill_led [16];

    initial begin
        checks = 0;
        errors = 0;
        bnc_led  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                     8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        bnc_dir  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                     1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        fill_led = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
                     8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

        reset          = 1'b1;
        run            = 1'b1;
        div_load       = 1'b0;
        div_value      = '0;
        mode_req_valid = 1'b0;
        mode_req       = 2'd0;
        #1;
        chk_reset_state();

        fork
            monitor_loop();
        join_none

        // BOUNCE from reset with div=4: one step every 4 cycles.
        for (int i = 0; i < 15; i++) push(4 * (i + 1), bnc_led[i], bnc_dir[i], 2'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // div_value=0 loaded on an edge that would have stepped.
        wait_cyc(63);
        div_load  = 1'b1;
        div_value = '0;
        push(65, 8'h04, 1'b0, 2'd0);
        push(66, 8'h08, 1'b0, 2'd0);
        push(67, 8'h10, 1'b0, 2'd0);
        push(68, 8'h20, 1'b0, 2'd0);
        wait_cyc(64);
        div_load = 1'b0;

        // Back to div=4, load again suppresses a would-be step.
        wait_cyc(68);
        div_load  = 1'b1;
        div_value = DIV_W'(4);
        push(73, 8'h40, 1'b0, 2'd0);
        wait_cyc(69);
        div_load = 1'b0;

        // ROT_R request mid-period.
        wait_cyc(74);
        chk("ready_before_req", 32'(mode_req_ready), 32'h1);
        mode_req_valid = 1'b1;
        mode_req       = 2'd2;
        push(77, 8'h80, 1'b1, 2'd2);
        push(81, 8'h40, 1'b1, 2'd2);
        push(85, 8'h20, 1'b1, 2'd2);
        push(89, 8'h10, 1'b1, 2'd2);
        push(93, 8'h08, 1'b1, 2'd2);
        push(97, 8'h04, 1'b1, 2'd2);
        push(101, 8'h02, 1'b1, 2'd2);
        push(105, 8'h01, 1'b1, 2'd2);
        push(109, 8'h80, 1'b1, 2'd2);
        wait_cyc(75);
        mode_req_valid = 1'b0;
        chk("ready_after_accept", 32'(mode_req_ready), 32'h0);
        wait_cyc(76);
        chk("ready_pending", 32'(mode_req_ready), 32'h0);
        wait_cyc(77);
        chk("ready_after_apply", 32'(mode_req_ready), 32'h1);

        // Switch to ROT_L, then leave a BOUNCE request pending and reset.
        wait_cyc(110);
        mode_req_valid = 1'b1;
        mode_req       = 2'd1;
        push(113, 8'h01, 1'b0, 2'd1);
        push(117, 8'h02, 1'b0, 2'd1);
        wait_cyc(111);
        mode_req_valid = 1'b0;
        wait_cyc(117);
        mode_req_valid = 1'b1;
        mode_req       = 2'd0;
        wait_cyc(118);
        mode_req_valid = 1'b0;
        chk("ready_pending_rotl", 32'(mode_req_ready), 32'h0);
        wait_cyc(119);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state();
        chk("rst_queue_drained", 32'(q.size()), 32'h0);

        // FILL with div=1: load and request accepted on the same edge.
        div_load       = 1'b1;
        div_value      = DIV_W'(1);
        mode_req_valid = 1'b1;
        mode_req       = 2'd3;
        push(2, 8'h01, 1'b0, 2'd3);
        for (int i = 0; i < 16; i++) push(3 + i, fill_led[i], 1'b0, 2'd3);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(1);
        div_load       = 1'b0;
        mode_req_valid = 1'b0;
        chk("fill_ready_pending", 32'(mode_req_ready), 32'h0);
        wait_cyc(2);
        chk("fill_ready_applied", 32'(mode_req_ready), 32'h1);

        // Pending request frozen by run=0 for 50 cycles.
        wait_cyc(18);
        div_load  = 1'b1;
        div_value = DIV_W'(4);
        wait_cyc(19);
        div_load       = 1'b0;
        mode_req_valid = 1'b1;
        mode_req       = 2'd0;
        wait_cyc(20);
        mode_req_valid = 1'b0;
        run            = 1'b0;
        chk("pause_ready", 32'(mode_req_ready), 32'h0);
        wait_cyc(70);
        chk("pause_led", 32'(LED), 32'h01);
        chk("pause_mode", 32'(mode), 32'h3);
        chk("pause_ready_held", 32'(mode_req_ready), 32'h0);
        chk("pause_pulse", 32'(step_pulse), 32'h0);
        run = 1'b1;
        push(73, 8'h01, 1'b0, 2'd0);
        push(77, 8'h02, 1'b0, 2'd0);
        wait_cyc(74);
        chk("resume_ready", 32'(mode_req_ready), 32'h1);
        wait_cyc(80);
        chk("final_queue_empty", 32'(q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
